// File: rtl/sprite_joueur.sv
// Player sprite compositor: a 2*HALF square centred on a per-frame latched
// position is drawn over the incoming background with a 2-cycle pipeline.
module sprite_joueur #(
    parameter int HALF      = 16,
    parameter int BLINK_BIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               SOF,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic               pix_valid,
    input  logic [23:0]        bg_rgb,
    input  logic signed [10:0] centerX,
    input  logic signed [10:0] centerY,
    output logic [23:0]        rgb,
    output logic               rgb_valid
);

    localparam logic signed [11:0] D_MIN = 12'(-HALF);
    localparam logic signed [11:0] D_MAX = 12'(HALF - 1);

    localparam logic [23:0] COL_BORDER = 24'h000000;
    localparam logic [23:0] COL_BODY_A = 24'hFFFF00;
    localparam logic [23:0] COL_BODY_B = 24'hFF8000;

    // Shadow centre and frame counter
    logic signed [10:0] cx_q, cx_d;
    logic signed [10:0] cy_q, cy_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    // Stage 1 registers
    logic               s1_hit_q, s1_hit_d;
    logic               s1_border_q, s1_border_d;
    logic [23:0]        s1_bg_q;
    logic               s1_valid_q;

    // Stage 2 registers
    logic [23:0]        rgb_q, rgb_d;
    logic               rgb_valid_q;

    logic signed [11:0] dx, dy;
    logic               in_x, in_y;

    // The centre only moves at frame boundaries so one frame never mixes two positions.
    always_comb begin
        cx_d        = cx_q;
        cy_d        = cy_q;
        frame_cnt_d = frame_cnt_q;
        if (SOF) begin
            cx_d        = centerX;
            cy_d        = centerY;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // 12-bit signed offsets: the unsigned pixel gets a zero MSB, the signed centre is sign-extended.
    always_comb begin
        dx          = $signed({1'b0, x}) - $signed({cx_q[10], cx_q});
        dy          = $signed({1'b0, y}) - $signed({cy_q[10], cy_q});
        in_x        = (dx >= D_MIN) && (dx <= D_MAX);
        in_y        = (dy >= D_MIN) && (dy <= D_MAX);
        s1_hit_d    = in_x && in_y && pix_valid;
        s1_border_d = s1_hit_d &&
                      ((dx == D_MIN) || (dx == D_MAX) || (dy == D_MIN) || (dy == D_MAX));
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (s1_valid_q) begin
            if (s1_border_q)
                rgb_d = COL_BORDER;
            else if (s1_hit_q)
                rgb_d = frame_cnt_q[BLINK_BIT] ? COL_BODY_B : COL_BODY_A;
            else
                rgb_d = s1_bg_q;
        end
    end

    // NOTE: every register, including the bg colour pipeline, is reset so the
    // outputs drop to black/invalid the instant reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx_q        <= 11'sd400;
            cy_q        <= 11'sd300;
            frame_cnt_q <= 8'd0;
            s1_hit_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s1_bg_q     <= 24'h000000;
            s1_valid_q  <= 1'b0;
            rgb_q       <= 24'h000000;
            rgb_valid_q <= 1'b0;
        end else begin
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            frame_cnt_q <= frame_cnt_d;
            s1_hit_q    <= s1_hit_d;
            s1_border_q <= s1_border_d;
            s1_bg_q     <= bg_rgb;
            s1_valid_q  <= pix_valid;
            rgb_q       <= rgb_d;
            rgb_valid_q <= s1_valid_q;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule

// File: doc/sprite_joueur.md
SPRITE_JOUEUR -- requirements
Module: sprite_joueur

Interface
REQ-001 Parameter HALF, default 16, half side of the square player sprite in pixels (sprite is 2*HALF x 2*HALF).
REQ-002 Parameter BLINK_BIT, default 4, index of the frame-counter bit that selects the body colour.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 SOF  input  1  one-cycle start-of-frame pulse.
REQ-006 x  input  11  unsigned horizontal coordinate of the current pixel.
REQ-007 y  input  11  unsigned vertical coordinate of the current pixel.
REQ-008 pix_valid  input  1  current pixel is in the active area (800x600).
REQ-009 bg_rgb  input  24  background colour of the current pixel, {R,G,B} 8 bits each.
REQ-010 centerX  input  11 signed  player centre X from the key controller; may change at any cycle.
REQ-011 centerY  input  11 signed  player centre Y from the key controller; may change at any cycle.
REQ-012 rgb  output  24  composited pixel colour.
REQ-013 rgb_valid  output  1  rgb is an active-area pixel.

Function
REQ-014 Shadow registers cx_s, cy_s SHALL load centerX, centerY on every cycle where SOF=1 and hold otherwise; all hit tests SHALL use only cx_s, cy_s (no tearing within a frame).
REQ-015 A pixel sampled in the same cycle as SOF SHALL be tested against the previous cx_s, cy_s; the new values apply from the next cycle.
REQ-016 An 8-bit frame counter SHALL increment on each SOF and wrap 255 -> 0.
REQ-017 Stage 1: dx = x - cx_s and dy = y - cy_s SHALL be computed in 12-bit signed arithmetic (no overflow for centre range -1..800 / -1..600).
REQ-018 Stage 1: hit SHALL be 1 when -HALF <= dx <= HALF-1 and -HALF <= dy <= HALF-1 and pix_valid=1; border SHALL be hit AND (dx = -HALF or dx = HALF-1 or dy = -HALF or dy = HALF-1).
REQ-019 Stage 1 SHALL register hit, border, bg_rgb and pix_valid.
REQ-020 Stage 2: rgb SHALL be 24'h000000 if border, else 24'hFFFF00 if hit and frame_cnt[BLINK_BIT]=0, else 24'hFF8000 if hit and frame_cnt[BLINK_BIT]=1, else the registered bg_rgb.
REQ-021 frame_cnt used in stage 2 SHALL be the value current when stage 2 registers.
REQ-022 Latency SHALL be exactly 2 cycles: rgb/rgb_valid at cycle n+2 correspond to x, y, pix_valid, bg_rgb at cycle n; throughput one pixel per cycle, no stalls.
REQ-023 rgb_valid SHALL equal pix_valid delayed 2 cycles; when rgb_valid=0, rgb SHALL be 24'h000000.
REQ-024 A sprite partly off-screen (cx_s < HALF or > 800-HALF, likewise Y) SHALL be clipped by the pix_valid gating only; no wrap-around to the opposite edge.
REQ-025 Centre values outside the screen (e.g. -1, 800) SHALL be accepted without saturation; only the on-screen part is drawn.

Reset
REQ-026 While reset_n=0: cx_s=400, cy_s=300, frame_cnt=0, all pipeline registers 0, rgb=24'h000000, rgb_valid=0.
REQ-027 Reset assertion mid-frame SHALL clear state immediately (asynchronously); after release, outputs SHALL be valid from the second clock edge and cx_s, cy_s stay 400/300 until the next SOF.

Verification
REQ-028 Reset, no SOF, pix_valid=1 at (400,300), bg=123456 -> two cycles later rgb=FFFF00, rgb_valid=1; at (384,300) -> 000000; at (416,300) -> 123456.
REQ-029 centerX changed 400->500 mid-frame without SOF -> pixel (500,300) still shows bg; after SOF pulse -> (500,300) shows FFFF00; pixel sampled on the SOF cycle uses old centre.
REQ-030 Apply 16 SOF pulses -> interior pixel changes FFFF00 to FF8000; after 32 pulses back to FFFF00; 256 pulses wrap frame_cnt to 0.
REQ-031 centerX=-1, centerY=-1 latched -> pixel (0,0) interior colour, (14,14) border 000000, (15,15) bg; centerX=800 -> (799,300) interior, no hit at x=0.
REQ-032 pix_valid toggling every cycle with random x, y -> rgb_valid equals pix_valid delayed 2, rgb=0 whenever rgb_valid=0.
REQ-033 reset_n pulsed low mid-frame -> rgb, rgb_valid go to 0 without a clock edge; cx_s, cy_s return to 400/300.
